transmission8_sched: RTL and testbench

//  Round-robin scheduler that shares the 8-channel transmission8 datapath between 8 requesters.
//  It drives the datapath select lines {A,B,C} and issues a one-hot grant to the requester that owns the path.

---
 rtl/trans_sched_pkg.sv | 21 ++
 rtl/transmission8_sched_if.sv | 26 ++
 rtl/trans_rr_pick.sv | 29 ++
 rtl/transmission8_sched.sv | 127 ++++++++++++
 tb/tb_transmission8_sched.sv | 310 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/trans_sched_pkg.sv
// Shared types and constants for the transmission8 round-robin scheduler.
// Holds the FSM state enum, channel/select widths and the one-hot helper.
package trans_sched_pkg;

    localparam int N_CH  = 8;
    localparam int SEL_W = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    function automatic logic [N_CH-1:0] onehot8(input logic [SEL_W-1:0] sel);
        logic [N_CH-1:0] v;
        v = '0;
        v[sel] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/transmission8_sched_if.sv
// Requester-side bundle of the transmission8 scheduler.
// Ports: iReq (requests in), oGnt (one-hot grant), A/B/C (select, A = MSB),
//        oBusy (path owned), oTimeout (forced-release pulse).
// master: requester side; slave: scheduler side.
interface transmission8_sched_if;
    import trans_sched_pkg::*;

    logic [N_CH-1:0] iReq;
    logic [N_CH-1:0] oGnt;
    logic            A;
    logic            B;
    logic            C;
    logic            oBusy;
    logic            oTimeout;

    modport master (
        output iReq,
        input  oGnt, A, B, C, oBusy, oTimeout
    );

    modport slave (
        input  iReq,
        output oGnt, A, B, C, oBusy, oTimeout
    );

endinterface

// File: rtl/trans_rr_pick.sv
// Combinational round-robin priority encoder.
// Ports: req[7:0] requests, ptr[2:0] search start; win[2:0] first set bit
//        at or above ptr (wrapping 7->0), any = at least one request.
module trans_rr_pick
    import trans_sched_pkg::*;
(
    input  logic [N_CH-1:0]  req,
    input  logic [SEL_W-1:0] ptr,
    output logic [SEL_W-1:0] win,
    output logic             any
);

    logic [SEL_W-1:0] idx;

    // Scan from the farthest slot back to ptr so the closest hit wins.
    always_comb begin
        win = '0;
        any = 1'b0;
        idx = '0;
        for (int k = N_CH - 1; k >= 0; k--) begin
            idx = ptr + SEL_W'(k);
            if (req[idx]) begin
                win = idx;
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/transmission8_sched.sv
// Round-robin scheduler sharing the transmission8 datapath among 8 requesters.
// Ports: clk, rst (async, active high), bus (slave modport: iReq in; oGnt,
//        A/B/C, oBusy, oTimeout out). All outputs are registered.
// Optional macro TRANS_SCHED_TIMEOUT_EN adds a hold counter that forces a
// release after MAX_HOLD grant cycles and pulses oTimeout.
module transmission8_sched
    import trans_sched_pkg::*;
#(
    parameter int MAX_HOLD = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    transmission8_sched_if.slave  bus
);

    state_t           state_q, state_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [N_CH-1:0]  gnt_q, gnt_d;
    logic             busy_q, busy_d;
    logic             to_q, to_d;
    logic [SEL_W-1:0] win;
    logic             any;
    logic             hold_max;
    logic             cur_req;

    trans_rr_pick u_pick (
        .req (bus.iReq),
        .ptr (ptr_q),
        .win (win),
        .any (any)
    );

    assign cur_req = bus.iReq[sel_q];

`ifdef TRANS_SCHED_TIMEOUT_EN
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    logic [7:0] hold_q, hold_d;

    assign hold_max = (hold_q == HOLD_LAST);

    // Zero on GRANT entry, counts while the grant is kept.
    always_comb begin
        hold_d = '0;
        if (state_q == GRANT && state_d == GRANT) begin
            hold_d = hold_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_q <= '0;
        end else begin
            hold_q <= hold_d;
        end
    end
`else
    logic unused_max_hold;

    assign hold_max        = 1'b0;
    assign unused_max_hold = ^8'(MAX_HOLD);
`endif

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        gnt_d   = gnt_q;
        busy_d  = busy_q;
        to_d    = 1'b0;
        unique case (state_q)
            IDLE, RELEASE: begin
                // sel is left alone here so the datapath never sees a toggle.
                if (any) begin
                    state_d = GRANT;
                    sel_d   = win;
                    gnt_d   = onehot8(win);
                    busy_d  = 1'b1;
                end else begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    busy_d  = 1'b0;
                end
            end
            GRANT: begin
                if (!cur_req || hold_max) begin
                    state_d = RELEASE;
                    gnt_d   = '0;
                    busy_d  = 1'b0;
                    ptr_d   = sel_q + 1'b1;
                    // Only a release with the owner still asking is forced.
                    to_d    = cur_req & hold_max;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            sel_q   <= '0;
            gnt_q   <= '0;
            busy_q  <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            gnt_q   <= gnt_d;
            busy_q  <= busy_d;
            to_q    <= to_d;
        end
    end

    assign bus.oGnt             = gnt_q;
    assign {bus.A, bus.B, bus.C} = sel_q;
    assign bus.oBusy            = busy_q;
    assign bus.oTimeout         = to_q;

endmodule

// File: tb/tb_transmission8_sched.sv
// Self-checking bench for transmission8_sched with a behavioural owner/pointer model.
// Honours TRANS_SCHED_TIMEOUT_EN the same way as the design.
module tb_transmission8_sched;

    localparam int MAX_HOLD = 16;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    transmission8_sched_if bus ();

    transmission8_sched #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    // Model: who owns the path (-1 = nobody), where the search starts,
    // last selected channel, cycles the owner has held, timeout pulse.
    int m_owner;
    int m_ptr;
    int m_sel;
    int m_cyc;
    bit m_to;

    logic [12:0] dut_v;
    assign dut_v = {bus.oGnt, bus.A, bus.B, bus.C, bus.oBusy, bus.oTimeout};

    function automatic int rr_pick(logic [7:0] r, int p);
        for (int k = 0; k < 8; k++) begin
            if (r[(p + k) % 8]) return (p + k) % 8;
        end
        return -1;
    endfunction

    function automatic logic [12:0] m_exp();
        logic [7:0] g;
        g = (m_owner >= 0) ? 8'(1 << m_owner) : 8'h00;
        return {g, 3'(m_sel), m_owner >= 0, m_to};
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_ptr   = 0;
        m_sel   = 0;
        m_cyc   = 0;
        m_to    = 1'b0;
    endtask

    task automatic model_step(logic [7:0] r);
        m_to = 1'b0;
        if (m_owner >= 0) begin
            bit timed;
            timed = 1'b0;
`ifdef TRANS_SCHED_TIMEOUT_EN
            timed = r[m_owner] && (m_cyc == MAX_HOLD);
`endif
            if (!r[m_owner] || timed) begin
                m_ptr   = (m_owner + 1) % 8;
                m_owner = -1;
                m_to    = timed;
            end else begin
                m_cyc++;
            end
        end else begin
            int w;
            w = rr_pick(r, m_ptr);
            if (w >= 0) begin
                m_owner = w;
                m_sel   = w;
                m_cyc   = 1;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step(bus.iReq);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.iReq = '0;
        model_reset();
        #12;
        n_vec++;
        if (dut_v !== 13'h0) begin
            n_err++;
            $display("FAIL reset_state got %h want %h", dut_v, 13'h0);
        end
        @(negedge clk);
        rst = 1'b0;
        bus.iReq = 8'h08;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_vec++;
            if (dut_v !== m_exp()) begin
                n_err++;
                $display("FAIL reset_pregrant c%0d got %h want %h", i, dut_v, m_exp());
            end
        end
        #2 rst = 1'b1;
        #1;
        n_vec++;
        if (dut_v !== 13'h0) begin
            n_err++;
            $display("FAIL reset_async got %h want %h", dut_v, 13'h0);
        end
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        bus.iReq = '0;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_vec++;
            if (dut_v !== m_exp()) begin
                n_err++;
                $display("FAIL reset_idle c%0d got %h want %h", i, dut_v, m_exp());
            end
        end
    endtask

    task automatic test_single();
        for (int i = 0; i < 7; i++) begin
            bus.iReq = (i < 5) ? 8'h20 : 8'h00;
            tick();
            n_vec++;
            if (dut_v !== m_exp()) begin
                n_err++;
                $display("FAIL single c%0d got %h want %h", i, dut_v, m_exp());
            end
            if (i == 0) begin
                n_vec++;
                if ({bus.oGnt, bus.A, bus.B, bus.C} !== {8'h20, 3'b101}) begin
                    n_err++;
                    $display("FAIL single_first got %h/%b%b%b want 20/101",
                             bus.oGnt, bus.A, bus.B, bus.C);
                end
            end
        end
    endtask

    task automatic test_fairness();
        int         order[$];
        logic [7:0] pg;
        logic [2:0] pabc;
        logic [7:0] r;
        bit         entry;
        rst = 1'b1;
        bus.iReq = '0;
        model_reset();
        #1;
        @(negedge clk);
        rst = 1'b0;
        pg   = bus.oGnt;
        pabc = {bus.A, bus.B, bus.C};
        for (int i = 0; i < 80 && order.size() < 9; i++) begin
            r = 8'hFF;
            if (m_owner >= 0 && m_cyc >= 3) r[m_owner] = 1'b0;
            bus.iReq = r;
            tick();
            n_vec++;
            if (dut_v !== m_exp()) begin
                n_err++;
                $display("FAIL fair c%0d got %h want %h", i, dut_v, m_exp());
            end
            entry = (pg == 8'h00) && (bus.oGnt != 8'h00);
            if (entry) begin
                for (int k = 0; k < 8; k++) begin
                    if (bus.oGnt[k]) order.push_back(k);
                end
            end
            n_vec++;
            if ({bus.A, bus.B, bus.C} !== pabc && !entry) begin
                n_err++;
                $display("FAIL fair_abc c%0d got %b%b%b want %b",
                         i, bus.A, bus.B, bus.C, pabc);
            end
            pg   = bus.oGnt;
            pabc = {bus.A, bus.B, bus.C};
        end
        for (int k = 0; k < 9; k++) begin
            n_vec++;
            if (k >= order.size()) begin
                n_err++;
                $display("FAIL fair_order #%0d got none want %0d", k, k % 8);
            end else if (order[k] != k % 8) begin
                n_err++;
                $display("FAIL fair_order #%0d got %0d want %0d", k, order[k], k % 8);
            end
        end
    endtask

    task automatic test_no_preempt();
        logic [7:0] sched [12];
        sched = '{8'h00, 8'h00, 8'h04, 8'h05, 8'h05, 8'h05,
                  8'h05, 8'h01, 8'h01, 8'h01, 8'h01, 8'h00};
        for (int i = 0; i < 12; i++) begin
            bus.iReq = sched[i];
            tick();
            n_vec++;
            if (dut_v !== m_exp()) begin
                n_err++;
                $display("FAIL nopre c%0d got %h want %h", i, dut_v, m_exp());
            end
        end
        // ch2 dropped at step 7 -> RELEASE at step 7, ch0 owns at step 8.
        n_vec++;
        if (bus.oGnt !== 8'h00) begin
            n_err++;
            $display("FAIL nopre_tail got %h want 00", bus.oGnt);
        end
    endtask

    task automatic test_wrap();
        logic [7:0] sched [11];
        sched = '{8'h40, 8'h40, 8'h00, 8'h03, 8'h03, 8'h03,
                  8'h02, 8'h02, 8'h02, 8'h00, 8'h00};
        for (int i = 0; i < 11; i++) begin
            bus.iReq = sched[i];
            tick();
            n_vec++;
            if (dut_v !== m_exp()) begin
                n_err++;
                $display("FAIL wrap c%0d got %h want %h", i, dut_v, m_exp());
            end
            if (i == 3 || i == 7) begin
                n_vec++;
                if (bus.oGnt !== ((i == 3) ? 8'h01 : 8'h02)) begin
                    n_err++;
                    $display("FAIL wrap_order c%0d got %h want %h",
                             i, bus.oGnt, (i == 3) ? 8'h01 : 8'h02);
                end
            end
        end
    endtask

    task automatic test_timeout();
        rst = 1'b1;
        bus.iReq = '0;
        model_reset();
        #1;
        @(negedge clk);
        rst = 1'b0;
        bus.iReq = 8'h30;
        for (int i = 0; i < 120; i++) begin
            tick();
            n_vec++;
            if (dut_v !== m_exp()) begin
                n_err++;
                $display("FAIL tmo c%0d got %h want %h", i, dut_v, m_exp());
            end
`ifdef TRANS_SCHED_TIMEOUT_EN
            if (i == 16 || i == 17) begin
                n_vec++;
                if ({bus.oGnt, bus.oTimeout} !==
                    ((i == 16) ? {8'h00, 1'b1} : {8'h20, 1'b0})) begin
                    n_err++;
                    $display("FAIL tmo_pulse c%0d got %h/%b", i, bus.oGnt, bus.oTimeout);
                end
            end
`else
            n_vec++;
            if ({bus.oGnt, bus.oTimeout} !== {8'h10, 1'b0}) begin
                n_err++;
                $display("FAIL tmo_hold c%0d got %h/%b want 10/0",
                         i, bus.oGnt, bus.oTimeout);
            end
`endif
        end
        bus.iReq = '0;
        for (int i = 0; i < 3; i++) tick();
    endtask

    task automatic test_random();
        logic [7:0] r;
        r = '0;
        for (int i = 0; i < 300; i++) begin
            for (int k = 0; k < 8; k++) begin
                if ($urandom_range(0, 5) == 0) r[k] = ~r[k];
            end
            bus.iReq = r;
            tick();
            n_vec++;
            if (dut_v !== m_exp()) begin
                n_err++;
                $display("FAIL rand c%0d req %h got %h want %h", i, r, dut_v, m_exp());
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_no_preempt();
        test_wrap();
        test_timeout();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
